rf_dbg_arbiter: RTL and testbench
=================================

Name: rf_dbg_arbiter

Overview:
- Shares the decode-stage register-file write port between pipeline writeback and an external debug access port. Also serves debug reads through a dedicated third read port.
- Sits between the writeback stage and the decode stage's register file. Drives that file's write-enable, write-address and write-data inputs.
- Pipeline writeback always has priority. A debug write that cannot find a free slot forces a pipeline halt through the hazard unit.

Parameters:
- XLEN, 32, data width of registers and debug data.
- MAX_WAIT, 8, contended cycles a pending debug write tolerates before halt_req is raised (>=1).
- HALT_TIMEOUT, 16, cycles to wait for halt_ack before aborting (used only with the optional feature).

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- wb_we  in  1  pipeline writeback enable.
- wb_rd  in  5  pipeline writeback destination.
- wb_data  in  XLEN  pipeline writeback data.
- rf_we  out  1  write enable to the register file.
- rf_waddr  out  5  write address to the register file.
- rf_wdata  out  XLEN  write data to the register file.
- rf_dbg_raddr  out  5  debug read-port address.
- rf_dbg_rdata  in  XLEN  debug read-port data (combinational from the register array).
- dbg_req_valid  in  1  debug request valid.
- dbg_req_ready  out  1  debug request ready.
- dbg_req_write  in  1  1 = write, 0 = read.
- dbg_req_addr  in  5  target register.
- dbg_req_wdata  in  XLEN  write data.
- dbg_rsp_valid  out  1  response valid.
- dbg_rsp_ready  in  1  response ready.
- dbg_rsp_rdata  out  XLEN  read data (0 for writes).
- dbg_rsp_err  out  1  error flag (timeout).
- halt_req  out  1  request to the hazard unit to stall fetch/decode and drain.
- halt_ack  in  1  pipeline drained; no further wb_we while held.

Behaviour:
- Reset is asynchronous and active-high, clock is clk.
- Reset values:
  - state = IDLE
  - dbg_req_ready = 1
  - dbg_rsp_valid = 0, dbg_rsp_rdata = 0, dbg_rsp_err = 0
  - halt_req = 0
  - wait counter = 0
  - latched addr/data = 0
- FSM states: IDLE, RD, WR_PEND, HALT, RESP.
- IDLE:
  - dbg_req_ready = 1.
  - On a valid&&ready handshake, latch addr, wdata and write.
  - Go to WR_PEND if write, otherwise RD.
- RD:
  - rf_dbg_raddr = latched addr.
  - At the next posedge, sample rf_dbg_rdata into dbg_rsp_rdata and go to RESP.
  - Read latency is 2 cycles from accept to rsp_valid.
  - Because writes land on negedge, the sampled value includes any same-cycle writeback.
- WR_PEND:
  - If !wb_we, fire a debug write this cycle and go to RESP.
  - Otherwise increment the counter. When counter == MAX_WAIT-1, set halt_req = 1 and go to HALT.
- HALT:
  - halt_req is held at 1.
  - When halt_ack && !wb_we, fire the debug write, clear halt_req and go to RESP.
  - A debug write never fires in the same cycle as wb_we.
- Write-port mux, combinational:
  - If wb_we: rf_we = 1, rf_waddr = wb_rd, rf_wdata = wb_data.
  - Else if debug write fires: rf_we = 1, rf_waddr = latched addr, rf_wdata = latched wdata.
  - Else rf_we = 0, rf_waddr = 0, rf_wdata = 0.
- Register x0:
  - A debug write to x0 is accepted and completed, but rf_we stays 0.
  - A debug read of x0 returns 0.
- RESP:
  - dbg_rsp_valid = 1; rdata and err are held stable.
  - On rsp_ready, go to IDLE and clear the counter.
  - dbg_req_ready = 0 in every state except IDLE. Only one transaction is outstanding at a time.
- Reset mid-transaction aborts it: no write is performed, no response is given, and halt_req drops immediately.
- wb_we is not blocked in any state. If the hazard unit violates halt_ack semantics, writeback still wins.

Optional Feature:
- Macro RF_DBG_TIMEOUT_EN.
- Defined:
  - In HALT, a second counter counts cycles without halt_ack.
  - On reaching HALT_TIMEOUT, drop halt_req, perform no write, and go to RESP with dbg_rsp_err = 1.
- Undefined:
  - HALT waits indefinitely.
  - dbg_rsp_err is tied 0 and HALT_TIMEOUT is unused.

Decomposition:
- Shared package rf_dbg_pkg holds:
  - the FSM state enum (3-bit encoding)
  - the REG_ZERO = 5'd0 constant
  - the response error code constants
- One natural sub-module: rf_wport_mux, the combinational priority mux for wb versus debug write. The FSM stays in the top module.

Test Plan:
- Read x5 (holding 0xDEADBEEF), idle pipeline: rsp_valid 2 cycles after accept, rdata = 0xDEADBEEF, err = 0.
- Write x7 = 0x1234 with wb_we = 0: rf_we=1, waddr=7, wdata=0x1234 in the cycle after accept; a subsequent read returns 0x1234.
- Write x3 with wb_we held 1 for 3 cycles: pipeline writes pass unaltered, debug write fires on the 4th cycle, halt_req is never asserted.
- Write with wb_we held 1 continuously, MAX_WAIT = 8: halt_req rises after 8 contended cycles. Then drop wb_we and raise halt_ack: debug write fires, halt_req falls the next cycle.
- Write x0 = 0xFFFF: response returned, rf_we never asserted from the debug side; a read of x0 returns 0.
- With RF_DBG_TIMEOUT_EN, halt_ack held 0: after 16 HALT cycles, rsp_valid=1, err=1, no write. Separately, assert reset while in HALT: halt_req=0, state IDLE, no rsp_valid.

Source files
------------

// File: rtl/rf_dbg_pkg.sv
// Shared types and constants for the register-file debug arbiter.
package rf_dbg_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD      = 3'd1,
        WR_PEND = 3'd2,
        HALT    = 3'd3,
        RESP    = 3'd4
    } state_e;

    localparam logic [4:0] REG_ZERO    = 5'd0;

    localparam logic       ERR_NONE    = 1'b0;
    localparam logic       ERR_TIMEOUT = 1'b1;

endpackage

// File: rtl/rf_dbg_arbiter_if.sv
// Debug access port: request channel (valid/ready) and response channel (valid/ready).
interface rf_dbg_arbiter_if #(
    parameter int XLEN = 32
) ();

    logic            req_valid;
    logic            req_ready;
    logic            req_write;
    logic [4:0]      req_addr;
    logic [XLEN-1:0] req_wdata;

    logic            rsp_valid;
    logic            rsp_ready;
    logic [XLEN-1:0] rsp_rdata;
    logic            rsp_err;

    modport master (
        output req_valid, req_write, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );

endinterface

// File: rtl/rf_wport_mux.sv
// Register-file write-port priority mux: writeback first, then debug write.
// Latency: combinational; backpressure: none, the losing debug write is retried by the caller.
module rf_wport_mux
    import rf_dbg_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            wb_we,
    input  logic [4:0]      wb_rd,
    input  logic [XLEN-1:0] wb_data,
    input  logic            dbg_we,
    input  logic [4:0]      dbg_addr,
    input  logic [XLEN-1:0] dbg_data,
    output logic            rf_we,
    output logic [4:0]      rf_waddr,
    output logic [XLEN-1:0] rf_wdata
);

    always_comb begin
        rf_we    = 1'b0;
        rf_waddr = REG_ZERO;
        rf_wdata = '0;
        if (wb_we) begin
            rf_we    = 1'b1;
            rf_waddr = wb_rd;
            rf_wdata = wb_data;
        end else if (dbg_we) begin
            rf_we    = 1'b1;
            rf_waddr = dbg_addr;
            rf_wdata = dbg_data;
        end
    end

endmodule

// File: rtl/rf_dbg_arbiter.sv
// Shares the RF write port between writeback and debug, serves debug reads; RF_DBG_TIMEOUT_EN aborts stuck halts.
// Read rsp 2 cycles after accept; debug writes yield to wb_we and raise halt_req after MAX_WAIT; one transaction in flight.
module rf_dbg_arbiter
    import rf_dbg_pkg::*;
#(
    parameter int XLEN         = 32,
    parameter int MAX_WAIT     = 8,
    parameter int HALT_TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wb_we,
    input  logic [4:0]        wb_rd,
    input  logic [XLEN-1:0]   wb_data,
    output logic              rf_we,
    output logic [4:0]        rf_waddr,
    output logic [XLEN-1:0]   rf_wdata,
    output logic [4:0]        rf_dbg_raddr,
    input  logic [XLEN-1:0]   rf_dbg_rdata,
    rf_dbg_arbiter_if.slave   dbg,
    output logic              halt_req,
    input  logic              halt_ack
);

    localparam int WCW = $clog2(MAX_WAIT + 1);

    if (MAX_WAIT < 1 || HALT_TIMEOUT < 1) begin : g_param_check
        $error("rf_dbg_arbiter: MAX_WAIT and HALT_TIMEOUT must be >= 1");
    end

    state_e          state_q, state_d;
    logic [WCW-1:0]  wcnt_q, wcnt_d;
    logic [4:0]      addr_q, addr_d;
    logic [XLEN-1:0] wdata_q, wdata_d;
    logic [XLEN-1:0] rdata_q, rdata_d;
    logic            dbg_fire;
    logic            dbg_we;
`ifdef RF_DBG_TIMEOUT_EN
    localparam int TCW = $clog2(HALT_TIMEOUT + 1);
    logic [TCW-1:0]  tcnt_q, tcnt_d;
    logic            err_q, err_d;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            wcnt_q  <= '0;
            addr_q  <= REG_ZERO;
            wdata_q <= '0;
            rdata_q <= '0;
`ifdef RF_DBG_TIMEOUT_EN
            tcnt_q  <= '0;
            err_q   <= ERR_NONE;
`endif
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
`ifdef RF_DBG_TIMEOUT_EN
            tcnt_q  <= tcnt_d;
            err_q   <= err_d;
`endif
        end
    end

    always_comb begin
        state_d  = state_q;
        wcnt_d   = wcnt_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        dbg_fire = 1'b0;
`ifdef RF_DBG_TIMEOUT_EN
        tcnt_d   = tcnt_q;
        err_d    = err_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (dbg.req_valid) begin
                    addr_d  = dbg.req_addr;
                    wdata_d = dbg.req_wdata;
                    rdata_d = '0;
`ifdef RF_DBG_TIMEOUT_EN
                    err_d   = ERR_NONE;
`endif
                    state_d = dbg.req_write ? WR_PEND : RD;
                end
            end
            RD: begin
                // x0 reads as zero regardless of what the array returns
                rdata_d = (addr_q == REG_ZERO) ? '0 : rf_dbg_rdata;
                state_d = RESP;
            end
            WR_PEND: begin
                if (!wb_we) begin
                    dbg_fire = 1'b1;
                    state_d  = RESP;
                end else if (wcnt_q == WCW'(MAX_WAIT - 1)) begin
                    state_d  = HALT;
                end else begin
                    wcnt_d   = wcnt_q + 1'b1;
                end
            end
            HALT: begin
                // writeback still wins even if the hazard unit acks early
                if (halt_ack && !wb_we) begin
                    dbg_fire = 1'b1;
                    state_d  = RESP;
                end
`ifdef RF_DBG_TIMEOUT_EN
                else if (!halt_ack) begin
                    if (tcnt_q == TCW'(HALT_TIMEOUT - 1)) begin
                        err_d   = ERR_TIMEOUT;
                        state_d = RESP;
                    end else begin
                        tcnt_d  = tcnt_q + 1'b1;
                    end
                end
`endif
            end
            RESP: begin
                if (dbg.rsp_ready) begin
                    state_d = IDLE;
                    wcnt_d  = '0;
`ifdef RF_DBG_TIMEOUT_EN
                    tcnt_d  = '0;
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign dbg_we        = dbg_fire && (addr_q != REG_ZERO);
    assign rf_dbg_raddr  = addr_q;
    assign halt_req      = (state_q == HALT);
    assign dbg.req_ready = (state_q == IDLE);
    assign dbg.rsp_valid = (state_q == RESP);
    assign dbg.rsp_rdata = rdata_q;
`ifdef RF_DBG_TIMEOUT_EN
    assign dbg.rsp_err   = err_q;
`else
    assign dbg.rsp_err   = ERR_NONE;
`endif

    rf_wport_mux #(
        .XLEN     (XLEN)
    ) u_wport_mux (
        .wb_we    (wb_we),
        .wb_rd    (wb_rd),
        .wb_data  (wb_data),
        .dbg_we   (dbg_we),
        .dbg_addr (addr_q),
        .dbg_data (wdata_q),
        .rf_we    (rf_we),
        .rf_waddr (rf_waddr),
        .rf_wdata (rf_wdata)
    );

endmodule

// File: tb/tb_rf_dbg_arbiter.sv
// Bench for rf_dbg_arbiter: directed scenarios with literal expectations, then random traffic against a transaction-level model.
module tb_rf_dbg_arbiter;

    localparam int XLEN         = 32;
    localparam int MAX_WAIT     = 8;
    localparam int HALT_TIMEOUT = 16;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              wb_we = 1'b0;
    logic [4:0]        wb_rd = '0;
    logic [XLEN-1:0]   wb_data = '0;
    logic              rf_we;
    logic [4:0]        rf_waddr;
    logic [XLEN-1:0]   rf_wdata;
    logic [4:0]        rf_dbg_raddr;
    logic [XLEN-1:0]   rf_dbg_rdata;
    logic              halt_req;
    logic              halt_ack = 1'b0;
    logic [XLEN-1:0]   rf [32];
    int                checks = 0;
    int                failures = 0;

    rf_dbg_arbiter_if #(.XLEN(XLEN)) dbg_if ();

    rf_dbg_arbiter #(
        .XLEN         (XLEN),
        .MAX_WAIT     (MAX_WAIT),
        .HALT_TIMEOUT (HALT_TIMEOUT)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .wb_we        (wb_we),
        .wb_rd        (wb_rd),
        .wb_data      (wb_data),
        .rf_we        (rf_we),
        .rf_waddr     (rf_waddr),
        .rf_wdata     (rf_wdata),
        .rf_dbg_raddr (rf_dbg_raddr),
        .rf_dbg_rdata (rf_dbg_rdata),
        .dbg          (dbg_if),
        .halt_req     (halt_req),
        .halt_ack     (halt_ack)
    );

    always #5 clk = ~clk;

    // Register array stand-in: writes land on negedge, x0 holds junk so the DUT must mask it.
    assign rf_dbg_rdata = rf[rf_dbg_raddr];
    always @(negedge clk) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) rf[i] = 32'h1000_0000 + 32'(i);
            rf[0] = 32'hBAD0_BAD0;
            rf[5] = 32'hDEAD_BEEF;
        end else if (rf_we && rf_waddr != 5'd0) begin
            rf[rf_waddr] = rf_wdata;
        end
    end

    task automatic cmp(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s at %0t: got %h, expected %h", nm, $time, got, exp);
        end
    endtask

    // Transaction-level reference: one outstanding request and how far it has progressed.
    bit          m_busy, m_write, m_done, m_halted, m_err;
    logic [4:0]  m_addr;
    logic [31:0] m_wdata, m_rdata;
    int          m_contend, m_hwait;

    function automatic bit m_fire();
        if (!m_busy || !m_write || m_done || wb_we) return 1'b0;
        return !m_halted || halt_ack;
    endfunction

    task automatic compare_outputs();
        bit          fire;
        logic        e_we;
        logic [4:0]  e_addr;
        logic [31:0] e_data;
        fire   = !reset && m_fire() && (m_addr != 5'd0);
        e_we   = wb_we || fire;
        e_addr = wb_we ? wb_rd : (fire ? m_addr : 5'd0);
        e_data = wb_we ? wb_data : (fire ? m_wdata : 32'd0);
        cmp("rf_we", rf_we, e_we);
        cmp("rf_waddr", rf_waddr, e_addr);
        cmp("rf_wdata", rf_wdata, e_data);
        if (reset) begin
            cmp("rst_req_ready", dbg_if.req_ready, 1);
            cmp("rst_rsp_valid", dbg_if.rsp_valid, 0);
            cmp("rst_halt_req", halt_req, 0);
            cmp("rst_rsp_rdata", dbg_if.rsp_rdata, 0);
            cmp("rst_rsp_err", dbg_if.rsp_err, 0);
        end else begin
            cmp("req_ready", dbg_if.req_ready, !m_busy);
            cmp("rsp_valid", dbg_if.rsp_valid, m_busy && m_done);
            cmp("halt_req", halt_req, m_busy && m_halted && !m_done);
            if (m_busy && m_done) begin
                cmp("rsp_rdata", dbg_if.rsp_rdata, m_rdata);
                cmp("rsp_err", dbg_if.rsp_err, m_err);
            end
            if (m_busy && !m_write && !m_done) cmp("dbg_raddr", rf_dbg_raddr, m_addr);
        end
    endtask

    task automatic model_step();
        if (reset) begin
            m_busy = 0;
            m_done = 0;
        end else if (!m_busy) begin
            if (dbg_if.req_valid) begin
                m_busy = 1; m_done = 0; m_halted = 0; m_err = 0;
                m_write = dbg_if.req_write; m_addr = dbg_if.req_addr; m_wdata = dbg_if.req_wdata;
                m_rdata = 0; m_contend = 0; m_hwait = 0;
            end
        end else if (m_done) begin
            if (dbg_if.rsp_ready) m_busy = 0;
        end else if (!m_write) begin
            m_rdata = (m_addr == 5'd0) ? 32'd0 : rf[m_addr];
            m_done  = 1;
        end else if (m_fire()) begin
            m_done = 1;
        end else if (!m_halted) begin
            m_contend++;
            if (m_contend == MAX_WAIT) m_halted = 1;
        end else begin
`ifdef RF_DBG_TIMEOUT_EN
            if (!halt_ack) begin
                m_hwait++;
                if (m_hwait == HALT_TIMEOUT) begin m_done = 1; m_err = 1; end
            end
`endif
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #4 compare_outputs();
            #3 model_step();
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic quiet();
        wb_we = 0; halt_ack = 0; dbg_if.req_valid = 0; dbg_if.rsp_ready = 0;
    endtask

    task automatic req(input logic w, input logic [4:0] a, input logic [31:0] d);
        dbg_if.req_valid = 1; dbg_if.req_write = w; dbg_if.req_addr = a; dbg_if.req_wdata = d;
    endtask

    task automatic contend(input int n);
        for (int i = 0; i < n; i++) begin
            step(); quiet();
            wb_we = 1; wb_rd = 5'(20 + i); wb_data = 32'(i);
            #1 cmp("contend_halt_low", halt_req, 0);
            cmp("contend_wb_pass", rf_waddr, 20 + i);
        end
    endtask

    initial begin
        quiet();
        dbg_if.req_write = 0; dbg_if.req_addr = '0; dbg_if.req_wdata = '0;
        repeat (3) step();
        #1 cmp("lit_reset_ready", dbg_if.req_ready, 1);
        cmp("lit_reset_halt", halt_req, 0);
        step(); reset = 0;

        // Read x5, idle pipeline
        step(); req(0, 5'd5, 0);
        #1 cmp("lit_rd_accept_ready", dbg_if.req_ready, 1);
        step(); quiet();
        #1 cmp("lit_rd_not_yet_valid", dbg_if.rsp_valid, 0);
        cmp("lit_rd_raddr", rf_dbg_raddr, 5);
        step(); dbg_if.rsp_ready = 1;
        #1 cmp("lit_rd_rsp_valid", dbg_if.rsp_valid, 1);
        cmp("lit_rd_rdata", dbg_if.rsp_rdata, 32'hDEAD_BEEF);
        cmp("lit_rd_err", dbg_if.rsp_err, 0);

        // Write x7 with an idle pipeline, then read it back
        step(); quiet(); req(1, 5'd7, 32'h1234);
        step(); quiet();
        #1 cmp("lit_wr_we", rf_we, 1);
        cmp("lit_wr_waddr", rf_waddr, 7);
        cmp("lit_wr_wdata", rf_wdata, 32'h1234);
        step(); dbg_if.rsp_ready = 1;
        #1 cmp("lit_wr_rdata_zero", dbg_if.rsp_rdata, 0);
        step(); quiet(); req(0, 5'd7, 0);
        step(); quiet();
        step(); dbg_if.rsp_ready = 1;
        #1 cmp("lit_rd_back_x7", dbg_if.rsp_rdata, 32'h1234);

        // Write x3 against 3 cycles of writeback
        step(); quiet(); req(1, 5'd3, 32'hA5A5_A5A5);
        contend(3);
        step(); quiet();
        #1 cmp("lit_x3_fire_waddr", rf_waddr, 3);
        cmp("lit_x3_fire_wdata", rf_wdata, 32'hA5A5_A5A5);
        step(); dbg_if.rsp_ready = 1;
        #1 cmp("lit_x3_rsp_valid", dbg_if.rsp_valid, 1);

        // Write x9 against continuous writeback: halt escalation
        step(); quiet(); req(1, 5'd9, 32'h99);
        contend(MAX_WAIT);
        step(); quiet(); wb_we = 1;
        #1 cmp("lit_halt_raised", halt_req, 1);
        step(); quiet(); halt_ack = 1;
        #1 cmp("lit_halt_fire_waddr", rf_waddr, 9);
        cmp("lit_halt_still_high", halt_req, 1);
        step(); quiet();
        #1 cmp("lit_halt_dropped", halt_req, 0);
        cmp("lit_halt_rsp_valid", dbg_if.rsp_valid, 1);
        dbg_if.rsp_ready = 1;

        // Write x0 is swallowed; read x0 returns zero
        step(); quiet(); req(1, 5'd0, 32'hFFFF);
        step(); quiet();
        #1 cmp("lit_x0_no_we", rf_we, 0);
        step(); dbg_if.rsp_ready = 1;
        #1 cmp("lit_x0_wr_rsp", dbg_if.rsp_valid, 1);
        step(); quiet(); req(0, 5'd0, 0);
        step(); quiet();
        step(); dbg_if.rsp_ready = 1;
        #1 cmp("lit_x0_rd_zero", dbg_if.rsp_rdata, 0);

`ifdef RF_DBG_TIMEOUT_EN
        step(); quiet(); req(1, 5'd4, 32'h44);
        contend(MAX_WAIT);
        repeat (HALT_TIMEOUT) begin
            step(); quiet();
            #1 cmp("lit_to_halt_held", halt_req, 1);
        end
        step(); quiet();
        #1 cmp("lit_to_rsp_valid", dbg_if.rsp_valid, 1);
        cmp("lit_to_err", dbg_if.rsp_err, 1);
        cmp("lit_to_halt_low", halt_req, 0);
        dbg_if.rsp_ready = 1;
`endif

        // Reset while halted aborts the transaction
        step(); quiet(); req(1, 5'd6, 32'h66);
        contend(MAX_WAIT);
        step(); quiet();
        #1 cmp("lit_pre_reset_halt", halt_req, 1);
        reset = 1;
        #1 cmp("lit_reset_halt_drop", halt_req, 0);
        cmp("lit_reset_ready_back", dbg_if.req_ready, 1);
        cmp("lit_reset_no_rsp", dbg_if.rsp_valid, 0);
        step(); step(); reset = 0;

        // Random traffic in segments of varying writeback pressure
        for (int seg = 0; seg < 40; seg++) begin
            int p_wb;
            int len;
            case ($urandom_range(0, 3))
                0:       p_wb = 0;
                1:       p_wb = 50;
                2:       p_wb = 95;
                default: p_wb = 100;
            endcase
            len = $urandom_range(20, 60);
            for (int i = 0; i < len; i++) begin
                step();
                wb_we             = ($urandom_range(0, 99) < p_wb);
                wb_rd             = 5'($urandom);
                wb_data           = $urandom;
                halt_ack          = ($urandom_range(0, 99) < 40);
                dbg_if.req_valid  = ($urandom_range(0, 99) < 50);
                dbg_if.req_write  = 1'($urandom);
                dbg_if.req_addr   = 5'($urandom);
                dbg_if.req_wdata  = $urandom;
                dbg_if.rsp_ready  = ($urandom_range(0, 99) < 60);
            end
        end

        step(); quiet();
        step();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
